button_debounce_pulse: RTL and testbench
========================================

BUTTON_DEBOUNCE_PULSE -- requirements
Module: button_debounce_pulse

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the cycles a synchronised key must stay stable to be accepted (20 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 SHALL have parameter CNT_W, default 24, meaning the debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic uses its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port key_n, input, 3 bits: raw active-low push-buttons, asynchronous to clk; bit i maps to channel i.
REQ-006 SHALL have ports button0, button1, button2, each an output of 1 bit: a one-cycle, active-high pulse per accepted press of channels 0, 1 and 2.
REQ-007 SHALL have port held, output, 3 bits: debounced active-high level of each channel.

Function
REQ-008 SHALL pass each key_n bit through a two-flop synchroniser before any other use.
REQ-009 SHALL run one independent FSM per channel with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-010 SHALL, in RELEASED, go to PRESS_WAIT with the counter cleared when the synchronised key reads pressed (low).
REQ-011 SHALL, in PRESS_WAIT, increment the counter each cycle the key reads pressed, and on the cycle the counter equals DEBOUNCE_CYCLES-1 go to PRESSED and clear the counter.
REQ-012 SHALL, in PRESS_WAIT, return to RELEASED with the counter cleared and no pulse if the key reads released on any cycle.
REQ-013 SHALL handle release symmetrically: PRESSED goes to RELEASE_WAIT on a released reading, and RELEASE_WAIT goes to RELEASED after DEBOUNCE_CYCLES stable released cycles, or back to PRESSED on any pressed reading.
REQ-014 SHALL register the buttonX pulse so that it is high for exactly the one cycle following the clock edge on which the FSM enters PRESSED from PRESS_WAIT.
REQ-015 SHALL never generate a pulse on a RELEASE_WAIT to PRESSED transition.
REQ-016 SHALL set held[i] high in PRESSED and RELEASE_WAIT and low otherwise, as a registered output.
REQ-017 SHALL give a latency from a stable key_n low sampled at edge N to a buttonX pulse high after edge N+DEBOUNCE_CYCLES+2.
REQ-018 SHALL emit at most one pulse per press, however long the key is held.
REQ-019 SHALL keep channels independent: simultaneous presses produce simultaneous pulses, and the downstream latch resolves priority.
REQ-020 SHALL never let the counter wrap; it saturates at DEBOUNCE_CYCLES-1 by construction.

Reset
REQ-021 SHALL, while rst_n is low and independent of clk, force the synchroniser flops to 1 (released), all FSMs to RELEASED, all counters to 0, button0..2 to 0 and held to 3'b000.
REQ-022 SHALL, on an assertion mid-press (any state), abort the press with no pulse at or after release; a key still held after reset needs the full DEBOUNCE_CYCLES again before it pulses.
REQ-023 SHALL expect rst_n deassertion synchronised externally; no internal reset synchroniser is required.

Structure
REQ-024 SHALL place in a shared package: the state typedef (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT), the DEBOUNCE_CYCLES default, and a simulation constant SIM_DEBOUNCE_CYCLES of 4.
REQ-025 SHALL implement one sub-module, debounce_channel (synchroniser, counter, FSM and pulse/held for one key), instantiated three times by the top level.

Verification (bench parameter DEBOUNCE_CYCLES=4, 10 ns clock)
REQ-026 SHALL check reset: rst_n=0 with key_n=3'b000 -> button0..2=0 and held=0 immediately, and no pulse before 6 cycles after release.
REQ-027 SHALL check a clean press: key_n[0] low and held for 10 cycles -> button0 high for exactly 1 cycle, 6 edges after the first low sample, and held[0]=1 until the debounced release.
REQ-028 SHALL check bounce rejection: key_n[1] toggled low/high every 2 cycles for 12 cycles, then high -> no button1 pulse and held[1]=0 throughout.
REQ-029 SHALL check a release glitch: after an accepted press on key_n[2], a 2-cycle high glitch -> no second button2 pulse and held[2] stays 1.
REQ-030 SHALL check simultaneous presses: key_n=3'b000 held for 10 cycles -> button0, button1 and button2 pulse on the same cycle, once each.
REQ-031 SHALL check reset mid-operation: rst_n=0 for 2 cycles while in PRESS_WAIT on channel 0 -> no pulse, and a fresh 6-cycle latency is required after reset.

Source files
------------

// File: rtl/button_debounce_pulse_pkg.sv
// Shared types and constants for the three-channel push-button debouncer.
package button_debounce_pulse_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // 20 ms at 50 MHz for real hardware; a short window keeps simulation fast.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
    localparam int SIM_DEBOUNCE_CYCLES     = 4;

endpackage

// File: rtl/button_debounce_pulse_channel.sv
// One debounced key: two-flop synchroniser, stability counter, press/release FSM,
// plus a registered single-cycle press pulse and a registered held level.
module debounce_channel
    import button_debounce_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_key;
    logic             pressed;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             pulse_next;
    logic             held_next;

    // Synchroniser resets to 1 so a key held through reset is seen as released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_key  <= 1'b1;
        end else begin
            sync_meta <= key_n;
            sync_key  <= sync_meta;
        end
    end

    assign pressed = ~sync_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RELEASED;
            cnt   <= '0;
            pulse <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pulse <= pulse_next;
            held  <= held_next;
        end
    end

    // The counter only runs in the two wait states and is cleared on every exit,
    // so it tops out at CNT_LIMIT and cannot wrap.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            RELEASED: begin
                cnt_next = '0;
                if (pressed) begin
                    state_next = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LIMIT) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                cnt_next = '0;
                if (!pressed) begin
                    state_next = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LIMIT) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

    // Only a PRESS_WAIT -> PRESSED step fires the pulse; a bounce back from
    // RELEASE_WAIT keeps the press without announcing it again.
    always_comb begin
        pulse_next = (state == PRESS_WAIT) && (state_next == PRESSED);
        held_next  = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    end

endmodule

// File: rtl/button_debounce_pulse.sv
// Three independent debounced push-buttons producing one-cycle press pulses
// and debounced held levels.
module button_debounce_pulse
    import button_debounce_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] key_n,
    output logic       button0,
    output logic       button1,
    output logic       button2,
    output logic [2:0] held
);

    logic [2:0] pulse;

    for (genvar i = 0; i < 3; i++) begin : g_channel
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_channel (
            .clk  (clk),
            .rst_n(rst_n),
            .key_n(key_n[i]),
            .pulse(pulse[i]),
            .held (held[i])
        );
    end

    assign button0 = pulse[0];
    assign button1 = pulse[1];
    assign button2 = pulse[2];

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Directed bench for button_debounce_pulse with a 4-cycle debounce window.
module tb_button_debounce_pulse;
    import button_debounce_pulse_pkg::*;

    // Key driven low at a negedge: first low sample is the next posedge N, the
    // pulse appears after edge N+6, i.e. at the 7th negedge that follows.
    localparam int PULSE_AT   = 7;
    localparam int RELEASE_AT = 7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] key_n;
    logic       button0;
    logic       button1;
    logic       button2;
    logic [2:0] held;
    logic [2:0] buttons;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign buttons = {button2, button1, button0};

    button_debounce_pulse #(
        .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
        .CNT_W          (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_n  (key_n),
        .button0(button0),
        .button1(button1),
        .button2(button2),
        .held   (held)
    );

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [2:0] exp;
        rst_n = 1'b0;
        key_n = 3'b000;
        #1;
        vectors++;
        if (buttons !== 3'b000 || held !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_immediate: buttons=%b held=%b expected 000/000", buttons, held);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            vectors++;
            if (buttons !== 3'b000 || held !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL reset_hold cycle %0d: buttons=%b held=%b expected 000/000", i, buttons, held);
            end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            exp = (i == PULSE_AT) ? 3'b111 : 3'b000;
            vectors++;
            if (buttons !== exp) begin
                miscompares++;
                $display("[TB] FAIL reset_release_latency cycle %0d: buttons=%b expected %b", i, buttons, exp);
            end
        end
        key_n = 3'b111;
        settle(12);
        vectors++;
        if (held !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_settle_held: held=%b expected 000", held);
        end
    endtask

    task automatic test_clean_press();
        logic [2:0] exp_btn;
        logic       exp_held;
        key_n = 3'b110;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            exp_btn  = (i == PULSE_AT) ? 3'b001 : 3'b000;
            exp_held = (i >= PULSE_AT);
            vectors++;
            if (buttons !== exp_btn || held[0] !== exp_held) begin
                miscompares++;
                $display("[TB] FAIL clean_press cycle %0d: buttons=%b held0=%b expected %b/%b",
                         i, buttons, held[0], exp_btn, exp_held);
            end
        end
        key_n = 3'b111;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            exp_held = (j < RELEASE_AT);
            vectors++;
            if (buttons !== 3'b000 || held[0] !== exp_held) begin
                miscompares++;
                $display("[TB] FAIL clean_release cycle %0d: buttons=%b held0=%b expected 000/%b",
                         j, buttons, held[0], exp_held);
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            key_n[1] = (i < 12) ? ~((i / 2) % 2 == 0) : 1'b1;
            @(negedge clk);
            vectors++;
            if (button1 !== 1'b0 || held[1] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bounce cycle %0d: button1=%b held1=%b expected 0/0", i, button1, held[1]);
            end
        end
    endtask

    task automatic test_release_glitch();
        logic [2:0] exp;
        key_n = 3'b011;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            exp = (i == PULSE_AT) ? 3'b100 : 3'b000;
            vectors++;
            if (buttons !== exp) begin
                miscompares++;
                $display("[TB] FAIL glitch_press cycle %0d: buttons=%b expected %b", i, buttons, exp);
            end
        end
        key_n = 3'b111;
        settle(2);
        key_n = 3'b011;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            vectors++;
            if (button2 !== 1'b0 || held[2] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL release_glitch cycle %0d: button2=%b held2=%b expected 0/1", i, button2, held[2]);
            end
        end
        key_n = 3'b111;
        settle(12);
        vectors++;
        if (held !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL glitch_settle_held: held=%b expected 000", held);
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp;
        key_n = 3'b000;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            exp = (i == PULSE_AT) ? 3'b111 : 3'b000;
            vectors++;
            if (buttons !== exp) begin
                miscompares++;
                $display("[TB] FAIL simultaneous cycle %0d: buttons=%b expected %b", i, buttons, exp);
            end
        end
        vectors++;
        if (held !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL simultaneous_held: held=%b expected 111", held);
        end
        key_n = 3'b111;
        settle(12);
    endtask

    task automatic test_reset_mid_press();
        logic [2:0] exp;
        key_n = 3'b110;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            vectors++;
            if (buttons !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL midreset_pre cycle %0d: buttons=%b expected 000", i, buttons);
            end
        end
        rst_n = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            vectors++;
            if (buttons !== 3'b000 || held !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL midreset_hold cycle %0d: buttons=%b held=%b expected 000/000", i, buttons, held);
            end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            exp = (i == PULSE_AT) ? 3'b001 : 3'b000;
            vectors++;
            if (buttons !== exp) begin
                miscompares++;
                $display("[TB] FAIL midreset_fresh_latency cycle %0d: buttons=%b expected %b", i, buttons, exp);
            end
        end
        key_n = 3'b111;
        settle(12);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_simultaneous();
        test_reset_mid_press();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
